// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences each instruction over 3-5 cycles and drives datapath controls.
module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [5:0]         Op,
  input  logic               Zero,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               IorD,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSrc,
  output logic               PCEn,
  output logic               IllegalOp,
  output logic [STATE_W-1:0] State
);

  typedef enum logic [STATE_W-1:0] {
    FETCH   = STATE_W'(0),
    DECODE  = STATE_W'(1),
    MEMADR  = STATE_W'(2),
    MEMRD   = STATE_W'(3),
    MEMWB   = STATE_W'(4),
    MEMWR   = STATE_W'(5),
    EXECUTE = STATE_W'(6),
    ALUWB   = STATE_W'(7),
    BRANCH  = STATE_W'(8),
    ADDIEX  = STATE_W'(9),
    ADDIWB  = STATE_W'(10),
    JUMP    = STATE_W'(11),
    ILLEGAL = STATE_W'(12)
  } state_t;

  typedef struct packed {
    logic       mem_write;
    logic       ir_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       illegal;
  } ctrl_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t state;
  ctrl_t  ctrl;
  logic   run;

  function automatic state_t next_of(input state_t s, input logic [5:0] op);
    state_t n;
    n = FETCH;
    case (s)
      FETCH:   n = DECODE;
      DECODE:
        case (op)
          OP_LW, OP_SW: n = MEMADR;
          OP_RTYPE:     n = EXECUTE;
          OP_BEQ:       n = BRANCH;
          OP_ADDI:      n = ADDIEX;
          OP_J:         n = JUMP;
          default:      n = ILLEGAL;
        endcase
      MEMADR:
        if (op == OP_LW)      n = MEMRD;
        else if (op == OP_SW) n = MEMWR;
        else                  n = FETCH;
      MEMRD:   n = MEMWB;
      EXECUTE: n = ALUWB;
      ADDIEX:  n = ADDIWB;
      default: n = FETCH;
    endcase
    return n;
  endfunction

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.ir_write  = 1'b1;
        c.alu_src_b = 2'b01;
        c.pc_write  = 1'b1;
      end
      DECODE:  c.alu_src_b = 2'b11;
      MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      MEMRD:   c.iord = 1'b1;
      MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_src    = 2'b01;
        c.branch    = 1'b1;
      end
      ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      ADDIWB:  c.reg_write = 1'b1;
      JUMP: begin
        c.pc_src   = 2'b10;
        c.pc_write = 1'b1;
      end
      ILLEGAL: c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // The first edge after reset only arms the FETCH outputs; State stays put.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= FETCH;
      ctrl  <= '0;
      run   <= 1'b0;
    end else if (!run) begin
      run   <= 1'b1;
      state <= FETCH;
      ctrl  <= decode(FETCH);
    end else begin
      state <= next_of(state, Op);
      ctrl  <= decode(next_of(state, Op));
    end
  end

  assign MemWrite  = ctrl.mem_write;
  assign IRWrite   = ctrl.ir_write;
  assign IorD      = ctrl.iord;
  assign RegDst    = ctrl.reg_dst;
  assign MemtoReg  = ctrl.mem_to_reg;
  assign RegWrite  = ctrl.reg_write;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUOp     = ctrl.alu_op;
  assign PCSrc     = ctrl.pc_src;
  assign PCEn      = ctrl.pc_write | (ctrl.branch & Zero);
  assign IllegalOp = ctrl.illegal;
  assign State     = state;

endmodule
